// File: rtl/tft_pkg.sv
// Shared pixel types, packing constants and colour expansion for the TFT unpack path.
package tft_pkg;

  localparam int WORD_W           = 32;
  localparam int DEF_PIXEL_BITS   = 16;
  localparam int DEF_FRAME_PIXELS = 800 * 480;
  localparam int PIX_PER_WORD     = WORD_W / DEF_PIXEL_BITS;
  localparam int POS_W            = $clog2(DEF_FRAME_PIXELS);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Narrow frames still need a one-bit counter.
  function automatic int pos_width(input int framePixels);
    return (framePixels > 1) ? $clog2(framePixels) : 1;
  endfunction

  // Replicating the top bits into the new LSBs maps full-scale 565 to full-scale 888.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t c;
    c.r = {p.r, p.r[4:2]};
    c.g = {p.g, p.g[5:4]};
    c.b = {p.b, p.b[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/tft_pos_counter.sv
// Frame position tracking: counts accepted pixels, pulses the frame end and
// flags a resync pulse that arrives part-way through a frame.
module tft_pos_counter
  import tft_pkg::*;
#(
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int POS_WIDTH    = POS_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic pixAccept_i,
  output logic frameEnd_o,
  output logic misalign_o
);

  localparam logic [POS_WIDTH-1:0] LastPos = POS_WIDTH'(FRAME_PIXELS - 1);

  if (FRAME_PIXELS < 2) begin : gBadFrame
    $error("tft_pos_counter: FRAME_PIXELS must be at least 2");
  end
  if ((64'd1 << POS_WIDTH) < 64'(FRAME_PIXELS)) begin : gBadWidth
    $error("tft_pos_counter: POS_WIDTH too narrow for FRAME_PIXELS");
  end

  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 frameEnd_q, frameEnd_d;
  logic                 misalign_q, misalign_d;
  logic                 wrap;

  assign wrap = pixAccept_i && (pos_q == LastPos);

  // A flush that lands on the final pixel of a frame is a clean boundary, not a misalignment.
  always_comb begin
    pos_d      = pos_q;
    frameEnd_d = wrap;
    misalign_d = misalign_q;
    if (flush_i) begin
      pos_d = '0;
      if ((pos_q != '0) && !wrap) begin
        misalign_d = 1'b1;
      end
    end else if (pixAccept_i) begin
      pos_d = wrap ? '0 : pos_q + POS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q      <= '0;
      frameEnd_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      frameEnd_q <= frameEnd_d;
      misalign_q <= misalign_d;
    end
  end

  assign frameEnd_o = frameEnd_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/tft_pixel_unpack.sv
// Unpacks 32-bit FIFO words into TFT pixels with 565->888 expansion and frame resync.
// Build macro TFT_UNPACK_SWAP_EN selects big-endian pixel order within a 16-bit-packed word.
module tft_pixel_unpack
  import tft_pkg::*;
#(
  parameter int PIXEL_BITS   = DEF_PIXEL_BITS,
  parameter int TFT_WIDTH    = 24,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                 CLK,
  input  logic                 RESET_N_IN,
  input  logic [WORD_W-1:0]    WORD_IN,
  input  logic                 WORD_REQ_IN,
  output logic                 WORD_ACK_OUT,
  input  logic                 FLUSH_IN,
  output logic [TFT_WIDTH-1:0] PIX_OUT,
  output logic                 PIX_REQ_OUT,
  input  logic                 PIX_ACK_IN,
  output logic                 FRAME_END_OUT,
  output logic                 MISALIGN_OUT
);

  localparam int   PosWidth = pos_width(FRAME_PIXELS);
  localparam logic LastIdx  = (PIXEL_BITS == 16) ? 1'(PIX_PER_WORD - 1) : 1'b0;

  if ((PIXEL_BITS != 16) && (PIXEL_BITS != 32)) begin : gBadPixelBits
    $error("tft_pixel_unpack: PIXEL_BITS must be 16 or 32");
  end
  if ((TFT_WIDTH != 16) && (TFT_WIDTH != 24)) begin : gBadTftWidth
    $error("tft_pixel_unpack: TFT_WIDTH must be 16 or 24");
  end

  logic [WORD_W-1:0] word_q, word_d;
  logic              bufValid_q, bufValid_d;
  logic              idx_q, idx_d;
  logic              last;
  logic              pixAccept;
  logic              wordAck;
  logic [15:0]       slice16;

  assign last      = (idx_q == LastIdx);
  assign pixAccept = bufValid_q & PIX_ACK_IN;
  // Refill in the same cycle the final pixel leaves, so streaming has no bubble.
  assign wordAck   = WORD_REQ_IN & ~FLUSH_IN & (~bufValid_q | (PIX_ACK_IN & last));

  assign WORD_ACK_OUT = wordAck;
  assign PIX_REQ_OUT  = bufValid_q;

  always_comb begin
    word_d     = word_q;
    bufValid_d = bufValid_q;
    idx_d      = idx_q;
    if (FLUSH_IN) begin
      bufValid_d = 1'b0;
      idx_d      = 1'b0;
    end else if (wordAck) begin
      word_d     = WORD_IN;
      bufValid_d = 1'b1;
      idx_d      = 1'b0;
    end else if (pixAccept) begin
      if (last) begin
        bufValid_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      word_q     <= '0;
      bufValid_q <= 1'b0;
      idx_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      bufValid_q <= bufValid_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
`ifdef TFT_UNPACK_SWAP_EN
    slice16 = idx_q ? word_q[15:0] : word_q[31:16];
`else
    slice16 = idx_q ? word_q[31:16] : word_q[15:0];
`endif
  end

  // Output is driven purely from registers; a cleared word register gives a zero pixel after reset.
  if (PIXEL_BITS == 32) begin : gWidePixel
    assign PIX_OUT = word_q[TFT_WIDTH-1:0];
  end else if (TFT_WIDTH == 24) begin : gExpand
    rgb888_t pix888;
    assign pix888  = rgb565_to_888(rgb565_t'(slice16));
    assign PIX_OUT = pix888;
  end else begin : gPassThrough
    assign PIX_OUT = slice16[TFT_WIDTH-1:0];
  end

  tft_pos_counter #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .POS_WIDTH    (PosWidth)
  ) uPosCounter (
    .clk_i       (CLK),
    .rst_ni      (RESET_N_IN),
    .flush_i     (FLUSH_IN),
    .pixAccept_i (pixAccept),
    .frameEnd_o  (FRAME_END_OUT),
    .misalign_o  (MISALIGN_OUT)
  );

endmodule

// File: tb/tb_tft_pixel_unpack.sv
// Bench for tft_pixel_unpack: directed steps plus a cycle-level scoreboard of pixels,
// handshakes, frame-end pulses and the misalign flag. Honours TFT_UNPACK_SWAP_EN.
module tb_tft_pixel_unpack;

  localparam int FramePixels = 4;
  localparam logic [23:0] Red   = 24'hFF0000;
  localparam logic [23:0] Green = 24'h00FF00;
`ifdef TFT_UNPACK_SWAP_EN
  localparam logic [23:0] FirstF80007E0  = Red;
  localparam logic [23:0] SecondF80007E0 = Green;
`else
  localparam logic [23:0] FirstF80007E0  = Green;
  localparam logic [23:0] SecondF80007E0 = Red;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N_IN = 1'b0;
  logic [31:0] WORD_IN;
  logic        WORD_REQ_IN;
  logic        WORD_ACK_OUT;
  logic        FLUSH_IN;
  logic [23:0] PIX_OUT;
  logic        PIX_REQ_OUT;
  logic        PIX_ACK_IN;
  logic        FRAME_END_OUT;
  logic        MISALIGN_OUT;

  always #5 CLK = ~CLK;

  tft_pixel_unpack #(
    .PIXEL_BITS   (16),
    .TFT_WIDTH    (24),
    .FRAME_PIXELS (FramePixels)
  ) dut (
    .CLK           (CLK),
    .RESET_N_IN    (RESET_N_IN),
    .WORD_IN       (WORD_IN),
    .WORD_REQ_IN   (WORD_REQ_IN),
    .WORD_ACK_OUT  (WORD_ACK_OUT),
    .FLUSH_IN      (FLUSH_IN),
    .PIX_OUT       (PIX_OUT),
    .PIX_REQ_OUT   (PIX_REQ_OUT),
    .PIX_ACK_IN    (PIX_ACK_IN),
    .FRAME_END_OUT (FRAME_END_OUT),
    .MISALIGN_OUT  (MISALIGN_OUT)
  );

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [23:0] expQ[$];
  int          modelCnt = 0;
  int          modelPos = 0;
  logic        pendEnd = 1'b0;
  logic        expMis = 1'b0;

  function automatic logic [23:0] expand565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [15:0] pixelOf(input logic [31:0] w, input int n);
`ifdef TFT_UNPACK_SWAP_EN
    return (n == 0) ? w[31:16] : w[15:0];
`else
    return (n == 0) ? w[15:0] : w[31:16];
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer a word until it is taken; returns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] w, output int waited);
    WORD_IN     = w;
    WORD_REQ_IN = 1'b1;
    waited      = 0;
    #1;
    while (!WORD_ACK_OUT && waited < 20) begin
      step();
      #1;
      waited++;
    end
    if (!WORD_ACK_OUT) checkOutput("word_ack_timeout", 32'(WORD_ACK_OUT), 32'd1);
    step();
  endtask

  // Scoreboard model, sampled mid-cycle ahead of the transferring edge.
  always @(negedge CLK) begin
    logic expReq;
    logic expWAck;
    logic pixAcc;
    logic wrap;
    if (!RESET_N_IN) begin
      checkOutput("rst_pix_req", 32'(PIX_REQ_OUT), 32'd0);
      checkOutput("rst_pix_out", 32'(PIX_OUT), 32'd0);
      checkOutput("rst_frame_end", 32'(FRAME_END_OUT), 32'd0);
      checkOutput("rst_misalign", 32'(MISALIGN_OUT), 32'd0);
      expQ.delete();
      modelCnt = 0;
      modelPos = 0;
      pendEnd  = 1'b0;
      expMis   = 1'b0;
    end else begin
      expReq  = (modelCnt != 0);
      expWAck = WORD_REQ_IN && !FLUSH_IN && ((modelCnt == 0) || (PIX_ACK_IN && modelCnt == 1));
      checkOutput("pix_req", 32'(PIX_REQ_OUT), 32'(expReq));
      checkOutput("word_ack", 32'(WORD_ACK_OUT), 32'(expWAck));
      checkOutput("frame_end", 32'(FRAME_END_OUT), 32'(pendEnd));
      checkOutput("misalign", 32'(MISALIGN_OUT), 32'(expMis));
      if (expReq && expQ.size() > 0) checkOutput("pix_out", 32'(PIX_OUT), 32'(expQ[0]));
      pixAcc  = expReq && PIX_ACK_IN;
      wrap    = pixAcc && (modelPos == FramePixels - 1);
      pendEnd = wrap;
      if (FLUSH_IN) begin
        if (modelPos != 0 && !wrap) expMis = 1'b1;
        modelPos = 0;
        modelCnt = 0;
        expQ.delete();
      end else begin
        if (pixAcc) begin
          void'(expQ.pop_front());
          modelCnt--;
          modelPos = wrap ? 0 : modelPos + 1;
        end
        if (expWAck) begin
          expQ.push_back(expand565(pixelOf(WORD_IN, 0)));
          expQ.push_back(expand565(pixelOf(WORD_IN, 1)));
          modelCnt = 2;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    WORD_IN     = '0;
    WORD_REQ_IN = 1'b0;
    FLUSH_IN    = 1'b0;
    PIX_ACK_IN  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_pix_req", 32'(PIX_REQ_OUT), 32'd0);
    checkOutput("reset_pix_out", 32'(PIX_OUT), 32'd0);
    checkOutput("reset_word_ack", 32'(WORD_ACK_OUT), 32'd0);
    checkOutput("reset_frame_end", 32'(FRAME_END_OUT), 32'd0);
    checkOutput("reset_misalign", 32'(MISALIGN_OUT), 32'd0);
    RESET_N_IN = 1'b1;
    step();

    // Basic unpack of one word.
    PIX_ACK_IN  = 1'b1;
    WORD_IN     = 32'hF800_07E0;
    WORD_REQ_IN = 1'b1;
    #1;
    checkOutput("basic_word_ack", 32'(WORD_ACK_OUT), 32'd1);
    step();
    WORD_REQ_IN = 1'b0;
    #1;
    checkOutput("basic_pix0", 32'(PIX_OUT), 32'(FirstF80007E0));
    checkOutput("basic_ack_once", 32'(WORD_ACK_OUT), 32'd0);
    step();
    checkOutput("basic_pix1", 32'(PIX_OUT), 32'(SecondF80007E0));
    step();
    checkOutput("basic_drain", 32'(PIX_REQ_OUT), 32'd0);

    // Back-to-back streaming: a word every second cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h001F_FFFF, waited);
      if (i > 0) checkOutput("stream_gap", 32'(waited), 32'd1);
    end
    WORD_REQ_IN = 1'b0;
    repeat (3) step();
    checkOutput("stream_drain", 32'(PIX_REQ_OUT), 32'd0);

    // Backpressure with ACK pattern 1,0,0,1.
    PIX_ACK_IN = 1'b0;
    applyStimulus(32'h1234_ABCD, waited);
    WORD_IN     = 32'h5678_9ABC;
    WORD_REQ_IN = 1'b1;
    PIX_ACK_IN  = 1'b1;
    #1;
    checkOutput("bp_ack_not_last", 32'(WORD_ACK_OUT), 32'd0);
    step();
    PIX_ACK_IN = 1'b0;
    #1;
    checkOutput("bp_hold_a", 32'(PIX_OUT), 32'(expand565(pixelOf(32'h1234_ABCD, 1))));
    checkOutput("bp_ack_full", 32'(WORD_ACK_OUT), 32'd0);
    step();
    checkOutput("bp_hold_b", 32'(PIX_OUT), 32'(expand565(pixelOf(32'h1234_ABCD, 1))));
    checkOutput("bp_req_held", 32'(PIX_REQ_OUT), 32'd1);
    step();
    PIX_ACK_IN = 1'b1;
    #1;
    checkOutput("bp_refill", 32'(WORD_ACK_OUT), 32'd1);
    step();
    WORD_REQ_IN = 1'b0;
    #1;
    checkOutput("bp_next_pix0", 32'(PIX_OUT), 32'(expand565(pixelOf(32'h5678_9ABC, 0))));
    repeat (3) step();

    // Align to a frame boundary.
    applyStimulus($urandom(), waited);
    WORD_REQ_IN = 1'b0;
    repeat (3) step();

    // Frame wrap after four pixels.
    applyStimulus($urandom(), waited);
    applyStimulus($urandom(), waited);
    WORD_REQ_IN = 1'b0;
    step();
    checkOutput("wrap_before", 32'(FRAME_END_OUT), 32'd0);
    step();
    checkOutput("wrap_pulse", 32'(FRAME_END_OUT), 32'd1);
    checkOutput("wrap_drained", 32'(PIX_REQ_OUT), 32'd0);
    step();
    checkOutput("wrap_single", 32'(FRAME_END_OUT), 32'd0);

    // Flush coincident with the last pixel of a frame.
    applyStimulus($urandom(), waited);
    applyStimulus($urandom(), waited);
    WORD_REQ_IN = 1'b0;
    step();
    FLUSH_IN = 1'b1;
    step();
    FLUSH_IN = 1'b0;
    #1;
    checkOutput("flush_last_end", 32'(FRAME_END_OUT), 32'd1);
    checkOutput("flush_last_nomis", 32'(MISALIGN_OUT), 32'd0);
    checkOutput("flush_last_req", 32'(PIX_REQ_OUT), 32'd0);
    step();

    // Misaligned flush after three of four pixels.
    applyStimulus($urandom(), waited);
    applyStimulus($urandom(), waited);
    WORD_REQ_IN = 1'b0;
    step();
    PIX_ACK_IN = 1'b0;
    FLUSH_IN   = 1'b1;
    step();
    FLUSH_IN   = 1'b0;
    PIX_ACK_IN = 1'b1;
    #1;
    checkOutput("mis_cleared", 32'(PIX_REQ_OUT), 32'd0);
    checkOutput("mis_set", 32'(MISALIGN_OUT), 32'd1);
    step();
    checkOutput("mis_sticky", 32'(MISALIGN_OUT), 32'd1);
    applyStimulus(32'h07E0_001F, waited);
    WORD_REQ_IN = 1'b0;
    checkOutput("mis_restart", 32'(PIX_OUT), 32'(expand565(pixelOf(32'h07E0_001F, 0))));
    repeat (3) step();

    // Order check then asynchronous reset mid-word.
    PIX_ACK_IN = 1'b0;
    applyStimulus(32'hF800_07E0, waited);
    WORD_REQ_IN = 1'b0;
    #1;
    checkOutput("order_first", 32'(PIX_OUT), 32'(FirstF80007E0));
    RESET_N_IN = 1'b0;
    #1;
    checkOutput("async_rst_req", 32'(PIX_REQ_OUT), 32'd0);
    checkOutput("async_rst_pix", 32'(PIX_OUT), 32'd0);
    checkOutput("async_rst_ack", 32'(WORD_ACK_OUT), 32'd0);
    checkOutput("async_rst_end", 32'(FRAME_END_OUT), 32'd0);
    checkOutput("async_rst_mis", 32'(MISALIGN_OUT), 32'd0);
    repeat (2) step();
    RESET_N_IN = 1'b1;
    step();
    checkOutput("post_reset_req", 32'(PIX_REQ_OUT), 32'd0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
